// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: reset values and
// the width of the pending-register population count.
package regfile_pkg;

    localparam logic REG_RESET_VAL  = 1'b0;
    localparam logic PEND_RESET_VAL = 1'b0;

    // A count of up to 2**addrW pending registers needs one extra bit.
    function automatic int countWidth(input int addrW);
        return addrW + 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the issue/datapath side (master) and the register file
// (slave). Port k of any multi-port field occupies slice [k*W +: W].
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) ();

    logic [NUM_RD*ADDR_W-1:0]     ReadRegister;
    logic [NUM_RD*DATA_W-1:0]     ReadData;
    logic [NUM_RD-1:0]            ReadBusy;
    logic [NUM_WR*ADDR_W-1:0]     WriteRegister;
    logic [NUM_WR*DATA_W-1:0]     WriteData;
    logic [NUM_WR-1:0]            RegWrite;
    logic                         ReserveEn;
    logic [ADDR_W-1:0]            ReserveRegister;
    logic [countWidth(ADDR_W)-1:0] PendingCount;

    modport master (
        output ReadRegister, WriteRegister, WriteData, RegWrite,
               ReserveEn, ReserveRegister,
        input  ReadData, ReadBusy, PendingCount
    );

    modport slave (
        input  ReadRegister, WriteRegister, WriteData, RegWrite,
               ReserveEn, ReserveRegister,
        output ReadData, ReadBusy, PendingCount
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits set by issue reservations and cleared by writes,
// with a registered count of how many registers are currently pending.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                          SubClk,
    input  logic                          ResetN,
    input  logic [NUM_WR*ADDR_W-1:0]      writeRegister,
    input  logic [NUM_WR-1:0]             regWrite,
    input  logic                          reserveEn,
    input  logic [ADDR_W-1:0]             reserveRegister,
    output logic [2**ADDR_W-1:0]          pendingNext,
    output logic [countWidth(ADDR_W)-1:0] pendingCount
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = countWidth(ADDR_W);

    logic [DEPTH-1:0] pending;
    logic [CW-1:0]    countNext;

    // Clears are applied before the set: a reserve in the same cycle as a
    // write belongs to a newer producer and must keep the register pending.
    always_comb begin
        pendingNext = pending;
        for (int k = 0; k < NUM_WR; k++) begin
            if (regWrite[k]) begin
                pendingNext[writeRegister[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (reserveEn && !((ZERO_REG != 0) && (reserveRegister == '0))) begin
            pendingNext[reserveRegister] = 1'b1;
        end
        countNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            countNext = countNext + CW'(pendingNext[i]);
        end
    end

    always_ff @(posedge SubClk) begin
        if (!ResetN) begin
            pending      <= {DEPTH{PEND_RESET_VAL}};
            pendingCount <= '0;
        end else begin
            pending      <= pendingNext;
            pendingCount <= countNext;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-through bypass; reads
// report the post-write data and post-update pending flag of each register.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         SubClk,
    input  logic         ResetN,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] regsNext [DEPTH];
    logic [DEPTH-1:0]  pendingNext;

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Ports are applied in ascending order so the highest-indexed writer
    // wins when several target the same register.
    always_comb begin
        regsNext = regs;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.RegWrite[k] && !isZeroReg(bus.WriteRegister[k*ADDR_W +: ADDR_W])) begin
                regsNext[bus.WriteRegister[k*ADDR_W +: ADDR_W]] = bus.WriteData[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge SubClk) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= {DATA_W{REG_RESET_VAL}};
            end
            bus.ReadData <= '0;
            bus.ReadBusy <= '0;
        end else begin
            regs <= regsNext;
            for (int j = 0; j < NUM_RD; j++) begin
                bus.ReadData[j*DATA_W +: DATA_W] <= isZeroReg(bus.ReadRegister[j*ADDR_W +: ADDR_W])
                    ? '0 : regsNext[bus.ReadRegister[j*ADDR_W +: ADDR_W]];
                bus.ReadBusy[j] <= pendingNext[bus.ReadRegister[j*ADDR_W +: ADDR_W]];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) scoreboard (
        .SubClk          (SubClk),
        .ResetN          (ResetN),
        .writeRegister   (bus.WriteRegister),
        .regWrite        (bus.RegWrite),
        .reserveEn       (bus.ReserveEn),
        .reserveRegister (bus.ReserveRegister),
        .pendingNext     (pendingNext),
        .pendingCount    (bus.PendingCount)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read ports, 2 write ports, register 0
// hardwired): hand-written vector table plus a reference-model sweep.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    typedef struct {
        logic        resetN;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic [5:0]  ec;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [5:0]  c;
    } exp_t;

    logic SubClk = 1'b0;
    logic ResetN;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .NUM_WR   (NW),
        .ZERO_REG (1)
    ) dut (
        .SubClk (SubClk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 SubClk = ~SubClk;

    exp_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mRegs [32];
    logic        mPend [32];
    vec_t        tbl   [15];

    function automatic vec_t mk(input logic resetN, input logic [1:0] we,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic re, input logic [4:0] ra,
                                input logic [4:0] rd0, input logic [4:0] rd1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input logic eb0, input logic eb1, input logic [5:0] ec);
        vec_t v;
        v.resetN = resetN; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.re = re; v.ra = ra; v.rd0 = rd0; v.rd1 = rd1;
        v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1; v.ec = ec;
        return v;
    endfunction

    task automatic compare(input string name, input string field,
                           input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, req);
        end
    endtask

    // Reference behaviour: reset clears all; otherwise writes in port order
    // (register 0 immune), each write clears pending, then reserve sets it.
    task automatic modelStep(input vec_t v);
        if (!v.resetN) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = '0;
                mPend[i] = 1'b0;
            end
        end else begin
            if (v.we[0] && v.wa0 != 0) mRegs[v.wa0] = v.wd0;
            if (v.we[0]) mPend[v.wa0] = 1'b0;
            if (v.we[1] && v.wa1 != 0) mRegs[v.wa1] = v.wd1;
            if (v.we[1]) mPend[v.wa1] = 1'b0;
            if (v.re && v.ra != 0) mPend[v.ra] = 1'b1;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL queue: got empty scoreboard, expected one entry");
        end else begin
            checks--;
            e = expQ.pop_front();
            compare(e.name, "ReadData0", bus.ReadData[31:0], e.d0);
            compare(e.name, "ReadData1", bus.ReadData[63:32], e.d1);
            compare(e.name, "ReadBusy0", {31'b0, bus.ReadBusy[0]}, {31'b0, e.b0});
            compare(e.name, "ReadBusy1", {31'b0, bus.ReadBusy[1]}, {31'b0, e.b1});
            compare(e.name, "PendingCount", {26'b0, bus.PendingCount}, {26'b0, e.c});
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit useModel, input string name);
        exp_t e;
        int   n;
        @(negedge SubClk);
        ResetN              = v.resetN;
        bus.RegWrite        = v.we;
        bus.WriteRegister   = {v.wa1, v.wa0};
        bus.WriteData       = {v.wd1, v.wd0};
        bus.ReserveEn       = v.re;
        bus.ReserveRegister = v.ra;
        bus.ReadRegister    = {v.rd1, v.rd0};
        modelStep(v);
        e.name = name;
        if (useModel) begin
            n = 0;
            for (int i = 0; i < 32; i++) n += int'(mPend[i]);
            e.d0 = (v.rd0 == 0) ? 32'h0 : mRegs[v.rd0];
            e.d1 = (v.rd1 == 0) ? 32'h0 : mRegs[v.rd1];
            e.b0 = mPend[v.rd0];
            e.b1 = mPend[v.rd1];
            e.c  = 6'(n);
        end else begin
            e.d0 = v.ed0; e.d1 = v.ed1; e.b0 = v.eb0; e.b1 = v.eb1; e.c = v.ec;
        end
        expQ.push_back(e);
        @(posedge SubClk);
        #1;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        ResetN              = 1'b0;
        bus.RegWrite        = '0;
        bus.WriteRegister   = '0;
        bus.WriteData       = '0;
        bus.ReserveEn       = 1'b0;
        bus.ReserveRegister = '0;
        bus.ReadRegister    = '0;

        //        rst we    wa0 wd0           wa1 wd1    re  ra  rd0 rd1 ed0           ed1           eb0 eb1 ec
        tbl[0]  = mk(1, 2'b01, 7, 32'hDEADBEEF, 0, 0,      0, 0,  0, 7,  32'h0,        32'hDEADBEEF, 0, 0, 0);
        tbl[1]  = mk(1, 2'b01, 0, 32'h1234,     0, 0,      0, 0,  0, 7,  32'h0,        32'hDEADBEEF, 0, 0, 0);
        tbl[2]  = mk(1, 2'b11, 3, 32'h11,       3, 32'h22, 0, 0,  3, 7,  32'h22,       32'hDEADBEEF, 0, 0, 0);
        tbl[3]  = mk(1, 2'b00, 0, 0,            0, 0,      1, 5,  5, 3,  32'h0,        32'h22,       1, 0, 1);
        tbl[4]  = mk(1, 2'b01, 5, 32'hA5,       0, 0,      0, 0,  5, 5,  32'hA5,       32'hA5,       0, 0, 0);
        tbl[5]  = mk(1, 2'b10, 0, 0,            5, 32'h5A, 1, 5,  5, 7,  32'h5A,       32'hDEADBEEF, 1, 0, 1);
        tbl[6]  = mk(1, 2'b01, 6, 32'h66,       0, 0,      0, 0,  6, 5,  32'h66,       32'h5A,       0, 1, 1);
        tbl[7]  = mk(1, 2'b00, 0, 0,            0, 0,      1, 0,  0, 5,  32'h0,        32'h5A,       0, 1, 1);
        tbl[8]  = mk(1, 2'b00, 0, 0,            0, 0,      1, 5,  5, 0,  32'h5A,       32'h0,        1, 0, 1);
        tbl[9]  = mk(1, 2'b01, 5, 32'h77,       0, 0,      0, 0,  5, 6,  32'h77,       32'h66,       0, 0, 0);
        tbl[10] = mk(1, 2'b01, 9, 32'hFF,       0, 0,      1, 1,  9, 1,  32'hFF,       32'h0,        0, 1, 1);
        tbl[11] = mk(1, 2'b00, 0, 0,            0, 0,      1, 2,  2, 1,  32'h0,        32'h0,        1, 1, 2);
        tbl[12] = mk(1, 2'b00, 0, 0,            0, 0,      1, 3,  3, 9,  32'h22,       32'hFF,       1, 0, 3);
        tbl[13] = mk(0, 2'b01, 4, 32'h44,       0, 0,      1, 6,  9, 4,  32'h0,        32'h0,        0, 0, 0);
        tbl[14] = mk(1, 2'b00, 0, 0,            0, 0,      0, 0,  4, 7,  32'h0,        32'h0,        0, 0, 0);

        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "reset0");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0), 1'b0, "reset1");
        for (int a = 0; a < 32; a += 2) begin
            applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1), 0, 0, 0, 0, 0), 1'b0, "resetRead");
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Reserve every register in turn; register 0 must never count.
        for (int a = 0; a < 32; a++) begin
            applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 5'(a), 5'(a), 0, 0, 0, 0, 0, 0), 1'b1, "sweep");
        end
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 1, 6'd31), 1'b0, "sweepFinal");

        for (int i = 0; i < 40; i++) begin
            v = mk(1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                   5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 0, 0, 0, 0, 0);
            applyStimulus(v, 1'b1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
